mem_single_stream_ctrl: RTL and testbench
=========================================

# mem_single_stream_ctrl

- Stream controller that sits directly in front of a `mem_single` instance and owns its `data`/`address`/`wr_en` inputs and its `q` output.
- Loads a frame of words from a valid/ready input stream into sequential addresses.
- On a `start` pulse, replays the stored frame in order on a valid/ready output stream, then clears the frame.
- Absorbs the RAM's one-cycle read latency so downstream backpressure never drops or duplicates a word.

## Interface
- `WIDTH`, 8: word width; must match the attached `mem_single`.
- `DEPTH`, 64: RAM depth in words; must match the attached `mem_single`; any value ≥ 2.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  write word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `start`  in  1  single-cycle request to replay the stored frame.
- `out_data`  out  WIDTH  replayed word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_last`  out  1  qualifies the final word of the frame; valid only while `out_valid` is high.
- `count`  out  `CLOG2(DEPTH+1)`  number of words stored in the current frame.
- `busy`  out  1  high while in READ.
- `mem_data`  out  WIDTH  to `mem_single.data`.
- `mem_address`  out  `CLOG2(DEPTH)`  to `mem_single.address`.
- `mem_wr_en`  out  1  to `mem_single.wr_en`.
- `mem_q`  in  WIDTH  from `mem_single.q`.

## Operation
- Two states: IDLE (load) and READ (replay). Reset enters IDLE.
- Reset values: `count`=0, `wr_ptr`=0, `rd_ptr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, no reads in flight.
- RAM contents are not cleared by reset.

IDLE
- `in_ready` = (`count` < DEPTH) & ~`start` (combinational).
- A write occurs when `in_valid` & `in_ready`.
  - `mem_wr_en`=1, `mem_address`=`wr_ptr`, `mem_data`=`in_data`, all combinational.
  - `wr_ptr` and `count` each increment by 1.
- When `count`==DEPTH, `in_ready`=0. Further input stalls; nothing is overwritten.
- If `start` is high and `count`>0, move to READ on the next edge. No write is accepted in that cycle.
- If `start` is high and `count`==0, `start` is ignored and the state stays IDLE. `in_ready` is still low in that cycle.

READ
- `in_ready`=0. `busy`=1.
- Read issue:
  - Drive `mem_wr_en`=0 and `mem_address`=`rd_ptr`.
  - Count the issue when `rd_ptr` < `count` and (buffer occupancy + reads in flight) < capacity. See Configuration for capacity.
  - `rd_ptr` increments on each issue.
- The word appears on `mem_q` one cycle after issue and is written into the output buffer on that edge.
- The output buffer presents its head on `out_data`/`out_valid`.
  - `out_last`=1 when the head word's index is `count`−1.
- When `out_valid` & `out_ready` & `out_last`, on the same edge:
  - return to IDLE;
  - `count`, `wr_ptr` and `rd_ptr` go to 0;
  - `out_valid` goes to 0.
- `start` is ignored while in READ.
- When not issuing, `mem_address` holds `rd_ptr` and `mem_wr_en`=0.

Boundary rules
- A frame of exactly DEPTH words replays all DEPTH words. `rd_ptr` never wraps.
- Address arithmetic is unsigned, `CLOG2(DEPTH)` bits. `count` and `rd_ptr` comparisons use `CLOG2(DEPTH+1)` bits.
- Asserting reset mid-READ aborts immediately. No further `out_valid` is produced; the next frame starts at address 0.

## Timing
- Write: accepted in cycle n, stored at the edge ending cycle n. `count` updates at that same edge.
- Start: `start` in cycle 0 → READ from cycle 1 → first read issued in cycle 1 → `mem_q` valid in cycle 2 → `out_valid`=1 from cycle 3.
- `out_valid` and `out_data` hold stable until accepted.

## Configuration
- Macro: `MEM_STREAM_SKID_EN`.
- Defined: output buffer capacity is 2 and reads issue back-to-back. With `out_ready` held high, throughput is one word per cycle.
- Undefined: capacity is 1 (at most one word buffered or in flight). Throughput is one word per 2 cycles. Ordering and `out_last` behaviour are identical to the defined case.

## Test plan
- Load 0x11,0x22,0x33,0x44, pulse `start`, hold `out_ready`=1 → outputs 0x11..0x44 in order.
  - `out_last` only on 0x44; first `out_valid` 3 cycles after `start`.
  - Consecutive cycles with `MEM_STREAM_SKID_EN`; every other cycle without.
  - `count`=0 and `busy`=0 afterwards.
- Write DEPTH words with `in_valid` held high → `in_ready` drops once `count`==DEPTH. The DEPTH+1th word is not written (`mem_wr_en` stays 0); replay returns exactly DEPTH words.
- Replay 8 words with `out_ready` toggling pseudo-randomly → all 8 values delivered exactly once, in order, with `out_data` stable while stalled.
- Pulse `start` with `count`=0 → stays IDLE; `busy`=0; `out_valid`=0. Pulse `start` together with `in_valid`=1 → no write occurs that cycle.
- Deassert `rst_n` after 2 of 6 words have been delivered → `out_valid`=0 and `count`=0 immediately. A new 2-word frame (0xA5, 0x5A) then replays 0xA5, 0x5A.

Source files
------------

// File: rtl/mem_single_stream_ctrl.sv
// Stream front-end for a mem_single RAM: loads a frame from a valid/ready input stream and replays it on start.
// Optional MEM_STREAM_SKID_EN widens the output buffer to two words for back-to-back reads.
module mem_single_stream_ctrl #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             start,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [CW-1:0]    count,
   output logic             busy,
   output logic [WIDTH-1:0] mem_data,
   output logic [AW-1:0]    mem_address,
   output logic             mem_wr_en,
   input  logic [WIDTH-1:0] mem_q
);

   typedef enum logic {IDLE, READ} state_t;

`ifdef MEM_STREAM_SKID_EN
   localparam logic [1:0] CAP = 2'd2;
`else
   localparam logic [1:0] CAP = 2'd1;
`endif

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t           state;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic [CW-1:0]    out_idx;
   logic [1:0]       occ;
   logic             pend;
   logic [WIDTH-1:0] skid_data;

   logic             pop;
   logic             wr_fire;
   logic             issue;
   logic [1:0]       fill;
   logic [CW-1:0]    next_idx;

   // NOTE: fill credits a word leaving this cycle, so a full buffer that is draining can still issue.
   assign pop         = out_valid & out_ready;
   assign fill        = occ + {1'b0, pend} - {1'b0, pop};
   assign next_idx    = out_idx + {{(CW-1){1'b0}}, pop};
   assign in_ready    = (state == IDLE) && (count < DEPTH_C) && !start;
   assign wr_fire     = in_valid & in_ready;
   assign issue       = (state == READ) && (rd_ptr < count) && (fill < CAP);
   assign mem_wr_en   = wr_fire;
   assign mem_data    = in_data;
   assign mem_address = (state == IDLE) ? wr_ptr : rd_ptr[AW-1:0];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_idx   <= '0;
         occ       <= '0;
         pend      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_fire) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  count  <= count + 1'b1;
               end
               if (start && (count != '0)) begin
                  state <= READ;
                  busy  <= 1'b1;
               end
            end
            READ: begin
               if (pop && out_last) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  count     <= '0;
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  out_idx   <= '0;
                  occ       <= '0;
                  pend      <= 1'b0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else begin
                  if (issue) rd_ptr <= rd_ptr + 1'b1;
                  pend      <= issue;
                  occ       <= fill;
                  out_idx   <= next_idx;
                  out_valid <= (fill != 2'd0);
                  out_last  <= (fill != 2'd0) && (next_idx == count - 1'b1);
                  // mem_q is captured only on the cycle after an issue; the head advances on pop.
                  if (pop) begin
                     if (occ == 2'd2) begin
                        out_data <= skid_data;
                        if (pend) skid_data <= mem_q;
                     end else if (pend) begin
                        out_data <= mem_q;
                     end
                  end else if (pend) begin
                     if (occ == 2'd0) out_data  <= mem_q;
                     else             skid_data <= mem_q;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_single_stream_ctrl.sv
// Directed bench for mem_single_stream_ctrl with a behavioural mem_single; honours MEM_STREAM_SKID_EN for timing checks.
module tb_mem_single_stream_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef MEM_STREAM_SKID_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 2;
`endif

   logic             clock = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             start;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [CW-1:0]    count;
   logic             busy;
   logic [WIDTH-1:0] mem_data;
   logic [AW-1:0]    mem_address;
   logic             mem_wr_en;
   logic [WIDTH-1:0] mem_q;

   logic [WIDTH-1:0] ram [0:DEPTH-1];
   logic [WIDTH-1:0] exp_q [$];
   int               n_checks = 0;
   int               n_fail   = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_wr_en) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
   end

   mem_single_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .start       (start),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .count       (count),
      .busy        (busy),
      .mem_data    (mem_data),
      .mem_address (mem_address),
      .mem_wr_en   (mem_wr_en),
      .mem_q       (mem_q)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [WIDTH-1:0] d, input int addr);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clock);
      check("wr_en", 32'(mem_wr_en), 32'd1);
      check("wr_addr", 32'(mem_address), 32'(addr));
      check("wr_data", 32'(mem_data), 32'(d));
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic replay(input int n, input bit rnd, input int stop_after);
      int got = 0;
      int cyc;
      int first_cyc = -1;
      int prev_cyc = -1;
      bit held = 1'b0;
      logic [WIDTH-1:0] held_data = '0;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cyc = 1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (got < n && cyc < 200 && !(stop_after > 0 && got >= stop_after)) begin
         @(negedge clock);
         if (held) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held_data});
         if (out_valid && first_cyc < 0) first_cyc = cyc;
         if (out_valid && out_ready) begin
            check($sformatf("word%0d", got), 32'(out_data), 32'(exp_q[got]));
            check($sformatf("last%0d", got), 32'(out_last), 32'(got == n - 1));
            if (!rnd && prev_cyc >= 0) check("gap", 32'(cyc - prev_cyc), 32'(GAP));
            prev_cyc = cyc;
            got++;
         end
         held      = out_valid && !out_ready;
         held_data = out_data;
         @(posedge clock); #1;
         cyc++;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      check("words_delivered", 32'(got), 32'(stop_after > 0 ? stop_after : n));
      if (!rnd) check("first_valid_cycle", 32'(first_cyc), 32'd3);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check_idle("reset");
      check("reset_out_last", 32'(out_last), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clock); #1;

      // start with an empty frame, together with in_valid
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(negedge clock);
      check("empty_start_in_ready", 32'(in_ready), 32'd0);
      check("empty_start_wr_en", 32'(mem_wr_en), 32'd0);
      @(posedge clock); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check_idle("empty_start");
      check("empty_start_ready_after", 32'(in_ready), 32'd1);
      @(posedge clock); #1;

      // Four-word frame, out_ready held high
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) load_word(exp_q[i], i);
      check("count4", 32'(count), 32'd4);
      replay(4, 1'b0, 0);
      check_idle("after4");

      // Full frame: DEPTH words with in_valid held, then one extra word that must stall
      exp_q = {};
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'(i * 8'h13 + 8'h01));
         load_word(exp_q[i], i);
      end
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clock);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_wr_en", 32'(mem_wr_en), 32'd0);
      check("full_count", 32'(count), 32'(DEPTH));
      @(posedge clock); #1;
      in_valid = 1'b0;
      replay(DEPTH, 1'b1, 0);
      check_idle("after_full");

      // Reset mid-replay after two of six words
      exp_q = {};
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(8'(8'h60 + i));
         load_word(exp_q[i], i);
      end
      replay(6, 1'b0, 2);
      rst_n = 1'b0;
      #1;
      check_idle("abort");
      @(negedge clock);
      check("abort_held_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clock); #1;

      exp_q = '{8'hA5, 8'h5A};
      load_word(8'hA5, 0);
      load_word(8'h5A, 1);
      replay(2, 1'b0, 0);
      check_idle("after_abort_frame");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
